pdm_capture_ctrl: RTL and testbench

//  Sequencer in front of and behind the CIC decimator of the PDM microphone path. Generates the

---
 rtl/pdm_capture_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_pdm_capture_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_capture_ctrl.sv
// PDM microphone capture sequencer: pdm_clk divider, bit capture towards the CIC,
// CIC settling discard and a first-word-fall-through output FIFO.
module pdm_capture_ctrl #(
    parameter int HALF_PERIOD = 25,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_EDGE = 0,
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 16,
    parameter int AMPL        = 1,
    parameter int DISCARD     = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    output logic                 pdm_clk,
    input  logic                 pdm_data,
    output logic                 cic_rst_n,
    output logic                 cic_in_valid,
    output logic [IN_WIDTH-1:0]  cic_in_sample,
    input  logic                 cic_out_valid,
    input  logic [OUT_WIDTH-1:0] cic_out_sample,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 overflow,
    output logic [1:0]           state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    localparam int DCW = $clog2(HALF_PERIOD);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(HALF_PERIOD - 1);
    localparam int DSW = $clog2(DISCARD + 2);
    localparam logic [DSW-1:0] DISC_LAST = DSW'((DISCARD > 0) ? DISCARD - 1 : 0);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [IN_WIDTH-1:0] POS = IN_WIDTH'(AMPL);
    localparam logic [IN_WIDTH-1:0] NEG = IN_WIDTH'(0) - POS;
    localparam logic CAP_LEVEL = (SAMPLE_EDGE == 0);

    logic [1:0]             state_r;
    logic [DCW-1:0]         div_cnt;
    logic                   pdm_clk_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   in_valid_r;
    logic [IN_WIDTH-1:0]    in_sample_r;
    logic                   cic_rst_r;
    logic [DSW-1:0]         disc_cnt;

    logic [OUT_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr, head_idx;
    logic [AW:0]            count, count_after_pop;
    logic [OUT_WIDTH-1:0]   m_data_r;
    logic                   ovf_r;

    logic running, start, capture, full, empty, pop, push_req, push, bypass;

    always_comb begin
        running         = (state_r != ST_IDLE);
        start           = (state_r == ST_IDLE) && enable;
        capture         = running && enable && (div_cnt == DIV_LAST) && (pdm_clk_r == CAP_LEVEL);
        full            = (count == FIFO_FULL);
        empty           = (count == '0);
        pop             = !empty && m_ready;
        push_req        = (state_r == ST_RUN) && cic_out_valid;
        push            = push_req && (!full || pop);
        head_idx        = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_after_pop = count - {{AW{1'b0}}, pop};
        bypass          = push && (count_after_pop == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pdm_data};
        end
    end

    // The captured bit goes straight into the sample register, so the strobe
    // appears the cycle after the capture cycle with the sample already valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            div_cnt     <= '0;
            pdm_clk_r   <= 1'b0;
            in_valid_r  <= 1'b0;
            in_sample_r <= '0;
            cic_rst_r   <= 1'b0;
            disc_cnt    <= '0;
        end else begin
            in_valid_r <= 1'b0;
            if (!running) begin
                div_cnt   <= '0;
                pdm_clk_r <= 1'b0;
                if (enable) begin
                    state_r   <= (DISCARD > 0) ? ST_WARMUP : ST_RUN;
                    cic_rst_r <= 1'b1;
                    disc_cnt  <= '0;
                end
            end else if (!enable) begin
                state_r   <= ST_IDLE;
                div_cnt   <= '0;
                pdm_clk_r <= 1'b0;
                cic_rst_r <= 1'b0;
            end else begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt   <= '0;
                    pdm_clk_r <= ~pdm_clk_r;
                end else begin
                    div_cnt <= div_cnt + DCW'(1);
                end
                if (capture) begin
                    in_valid_r  <= 1'b1;
                    in_sample_r <= sync_r[SYNC_STAGES-1] ? POS : NEG;
                end
                if (state_r == ST_WARMUP && cic_out_valid) begin
                    if (disc_cnt == DISC_LAST) begin
                        state_r <= ST_RUN;
                    end else begin
                        disc_cnt <= disc_cnt + DSW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cic_out_sample;
        end
    end

    // m_data is the registered next head; a push into an (effectively) empty
    // FIFO bypasses the memory so the head is never one cycle stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            m_data_r <= '0;
            ovf_r    <= 1'b0;
        end else if (start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_r  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW + 1)'(1);
            end
            if (push_req && full && !pop) begin
                ovf_r <= 1'b1;
            end
            if (bypass) begin
                m_data_r <= cic_out_sample;
            end else if (pop) begin
                m_data_r <= mem[head_idx];
            end
        end
    end

    assign pdm_clk       = pdm_clk_r;
    assign cic_rst_n     = cic_rst_r;
    assign cic_in_valid  = in_valid_r;
    assign cic_in_sample = in_sample_r;
    assign m_valid       = !empty;
    assign m_data        = m_data_r;
    assign overflow      = ovf_r;
    assign state         = state_r;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl: divider/capture timing, warm-up discard,
// FIFO ordering, overflow, enable handling and asynchronous reset.
module tb_pdm_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        pdm_clk;
    logic        pdm_data = 1'b1;
    logic        cic_rst_n;
    logic        cic_in_valid;
    logic [15:0] cic_in_sample;
    logic        cic_out_valid = 1'b0;
    logic [15:0] cic_out_sample = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [15:0] m_data;
    logic        overflow;
    logic [1:0]  state;

    int n_chk = 0;
    int n_err = 0;

    pdm_capture_ctrl #(
        .HALF_PERIOD(4),
        .SYNC_STAGES(2),
        .SAMPLE_EDGE(0),
        .IN_WIDTH(16),
        .OUT_WIDTH(16),
        .AMPL(1),
        .DISCARD(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .pdm_clk(pdm_clk),
        .pdm_data(pdm_data),
        .cic_rst_n(cic_rst_n),
        .cic_in_valid(cic_in_valid),
        .cic_in_sample(cic_in_sample),
        .cic_out_valid(cic_out_valid),
        .cic_out_sample(cic_out_sample),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .overflow(overflow),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        cov;
        logic [15:0] din;
        logic        rdy;
        logic [1:0]  st;
        logic        mv;
        logic        cd;
        logic [15:0] data;
        logic        ovf;
    } vec_t;

    vec_t vecs [29];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        //          en  cov  din  rdy   st  mv  cd  data ovf
        vecs[0]  = '{1, 1, 16'd10, 0,  1, 0, 0, 16'd0,  0};
        vecs[1]  = '{1, 1, 16'd20, 0,  2, 0, 0, 16'd0,  0};
        vecs[2]  = '{1, 1, 16'd30, 0,  2, 1, 1, 16'd30, 0};
        vecs[3]  = '{1, 0, 16'd0,  1,  2, 0, 0, 16'd0,  0};
        vecs[4]  = '{1, 1, 16'd1,  0,  2, 1, 1, 16'd1,  0};
        vecs[5]  = '{1, 1, 16'd2,  0,  2, 1, 1, 16'd1,  0};
        vecs[6]  = '{1, 1, 16'd3,  0,  2, 1, 1, 16'd1,  0};
        vecs[7]  = '{1, 1, 16'd4,  0,  2, 1, 1, 16'd1,  0};
        vecs[8]  = '{1, 1, 16'd5,  0,  2, 1, 1, 16'd1,  1};
        vecs[9]  = '{1, 0, 16'd0,  1,  2, 1, 1, 16'd2,  1};
        vecs[10] = '{1, 0, 16'd0,  1,  2, 1, 1, 16'd3,  1};
        vecs[11] = '{0, 0, 16'd0,  0,  0, 1, 1, 16'd3,  1};
        vecs[12] = '{1, 0, 16'd0,  0,  1, 0, 0, 16'd0,  0};
        vecs[13] = '{1, 1, 16'd99, 0,  1, 0, 0, 16'd0,  0};
        vecs[14] = '{1, 1, 16'd98, 0,  2, 0, 0, 16'd0,  0};
        vecs[15] = '{1, 1, 16'd11, 0,  2, 1, 1, 16'd11, 0};
        vecs[16] = '{1, 1, 16'd12, 0,  2, 1, 1, 16'd11, 0};
        vecs[17] = '{1, 1, 16'd13, 0,  2, 1, 1, 16'd11, 0};
        vecs[18] = '{1, 1, 16'd14, 0,  2, 1, 1, 16'd11, 0};
        vecs[19] = '{1, 1, 16'd15, 1,  2, 1, 1, 16'd12, 0};
        vecs[20] = '{1, 0, 16'd0,  1,  2, 1, 1, 16'd13, 0};
        vecs[21] = '{1, 0, 16'd0,  1,  2, 1, 1, 16'd14, 0};
        vecs[22] = '{1, 0, 16'd0,  1,  2, 1, 1, 16'd15, 0};
        vecs[23] = '{1, 0, 16'd0,  1,  2, 0, 0, 16'd0,  0};
        vecs[24] = '{1, 1, 16'd16, 0,  2, 1, 1, 16'd16, 0};
        vecs[25] = '{1, 1, 16'd17, 1,  2, 1, 1, 16'd17, 0};
        vecs[26] = '{1, 0, 16'd0,  1,  2, 0, 0, 16'd0,  0};
        vecs[27] = '{0, 1, 16'd18, 0,  0, 1, 1, 16'd18, 0};
        vecs[28] = '{0, 0, 16'd0,  1,  0, 0, 0, 16'd0,  0};

        // Reset, then idle with enable low
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("idle_pdm_clk", pdm_clk, 0);
        chk("idle_cic_rst_n", cic_rst_n, 0);
        chk("idle_m_valid", m_valid, 0);
        chk("idle_overflow", overflow, 0);
        chk("idle_state", state, 0);
        chk("idle_in_valid", cic_in_valid, 0);
        chk("idle_in_sample", cic_in_sample, 0);
        chk("idle_m_data", m_data, 0);

        // Divider and capture timing, pdm_data 1 then 0
        enable = 1'b1;
        tick();
        chk("start_state", state, 1);
        chk("start_cic_rst_n", cic_rst_n, 1);
        chk("start_pdm_clk", pdm_clk, 0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk("div_pdm_clk", pdm_clk, ((k / 4) % 2) == 1);
            chk("cap_in_valid", cic_in_valid, (k % 8) == 0);
            if ((k % 8) == 0)
                chk("cap_in_sample", cic_in_sample, (k == 40) ? 32'h0000FFFF : 32'h1);
            if (k == 32) pdm_data = 1'b0;
        end
        chk("warmup_state", state, 1);

        // Table: warm-up discard, FIFO fill/overflow/drain, re-enable, pass-through
        for (int i = 0; i < 29; i++) begin
            enable         = vecs[i].en;
            cic_out_valid  = vecs[i].cov;
            cic_out_sample = vecs[i].din;
            m_ready        = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_state", i), state, vecs[i].st);
            chk($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].mv);
            chk($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
            if (vecs[i].cd)
                chk($sformatf("vec%0d_m_data", i), m_data, vecs[i].data);
        end
        cic_out_valid = 1'b0;
        m_ready       = 1'b0;

        // Disable in the capture cycle of a high phase
        enable = 1'b1;
        tick();
        chk("re_state", state, 1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("re_pdm_clk", pdm_clk, k >= 4);
        end
        enable = 1'b0;
        tick();
        chk("stop_pdm_clk", pdm_clk, 0);
        chk("stop_in_valid", cic_in_valid, 0);
        chk("stop_cic_rst_n", cic_rst_n, 0);
        chk("stop_state", state, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("stopped_in_valid", cic_in_valid, 0);
            chk("stopped_pdm_clk", pdm_clk, 0);
        end

        // Re-enable restarts the divider from zero
        enable = 1'b1;
        tick();
        chk("re2_state", state, 1);
        chk("re2_m_valid", m_valid, 0);
        chk("re2_overflow", overflow, 0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("re2_pdm_clk", pdm_clk, (k >= 4) && (k < 8));
        end
        chk("re2_in_valid", cic_in_valid, 1);
        chk("re2_in_sample", cic_in_sample, 32'h0000FFFF);

        cic_out_valid  = 1'b1;
        cic_out_sample = 16'h0055;
        tick();
        tick();
        chk("re2_run", state, 2);
        for (int v = 1; v <= 5; v++) begin
            cic_out_sample = 16'(v);
            tick();
        end
        cic_out_valid = 1'b0;
        chk("pre_rst_overflow", overflow, 1);
        chk("pre_rst_m_valid", m_valid, 1);
        chk("pre_rst_m_data", m_data, 1);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_pdm_clk", pdm_clk, 0);
        chk("arst_cic_rst_n", cic_rst_n, 0);
        chk("arst_in_valid", cic_in_valid, 0);
        chk("arst_in_sample", cic_in_sample, 0);
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_data", m_data, 0);
        chk("arst_overflow", overflow, 0);
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_state", state, 0);
        chk("post_rst_m_valid", m_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
